// File: rtl/sr_chain_pkg.sv
// sr_chain_pkg -- shared types and helpers for the 74HC595 chain loader.
//
// Contents:
//   sr_state_t       loader FSM state encoding (ST_BLANK exists only when
//                    SR_CHAIN_BLANK_EN is defined)
//   SR_STATE_W       width of the state encoding
//   sr_cnt_width()   width of a down-counter that must hold 0..max_count
//   sr_frame_cycles() cycles from handshake to frame_done for one frame
//
// Configuration macro: SR_CHAIN_BLANK_EN (adds the post-latch OE_ blank state).

package sr_chain_pkg;

  localparam int SR_STATE_W = 3;

  typedef enum logic [SR_STATE_W-1:0] {
    ST_CLEAR_MR    = 3'd0,
    ST_CLEAR_LATCH = 3'd1,
    ST_IDLE        = 3'd2,
    ST_SHIFT_LO    = 3'd3,
    ST_SHIFT_HI    = 3'd4,
    ST_LATCH       = 3'd5
`ifdef SR_CHAIN_BLANK_EN
    ,
    ST_BLANK       = 3'd6
`endif
  } sr_state_t;

  // Width of a counter holding values 0..max_count; never narrower than 1.
  function automatic int sr_cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end else begin
      return $clog2(max_count + 1);
    end
  endfunction

  // Handshake cycle is cycle 0; frame_done appears this many cycles later.
  function automatic int sr_frame_cycles(input int chain_bits, input int clk_div,
                                         input int blank);
    return (2 * chain_bits + 1) * clk_div + 1 + blank;
  endfunction

endpackage

// File: rtl/sr_chain_loader_div_tick.sv
// sr_div_tick -- reloadable CLK_DIV down-counter shared by every timed state
// of the chain loader.
//
// The counter holds "cycles left in the current state minus one". tick is
// high in the last cycle of each CLK_DIV-long interval; the counter reloads
// itself on that cycle so consecutive timed states chain without a gap.
// restart (or reset) forces a reload, which is how a new interval is aligned
// to the cycle after the FSM leaves an untimed state.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset (reloads the counter)
//   restart  synchronous reload request
//   tick     terminal-count flag, derived only from the counter register

module sr_div_tick
  import sr_chain_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int                DIV_W  = sr_cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]  RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  ZERO   = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]  ONE    = DIV_W'(1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("sr_div_tick: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] cnt_r;

  // Down-count, reloading on terminal count, restart or reset.
  always_ff @(posedge clk) begin
    if (reset || restart || (cnt_r == ZERO)) begin
      cnt_r <= RELOAD;
    end else begin
      cnt_r <= cnt_r - ONE;
    end
  end

  assign tick = (cnt_r == ZERO);

endmodule

// File: rtl/sr_chain_loader.sv
// sr_chain_loader -- multi-channel driver for chains of 74HC595-style
// serial-in/parallel-out shift registers.
//
// One parallel frame (one word per channel) is accepted through a
// valid/ready handshake and shifted MSB-first onto each channel's DS line.
// All chains share SHCP/STCP/MR_/OE_. After reset the chains are cleared
// (MR_ low, then a storage latch with MR_ still low) so their outputs read
// all-zero before the first frame.
//
// Ports:
//   master_clk  sole clock, rising edge
//   reset       synchronous active-high reset; aborts any frame in flight
//   in_valid    frame offered
//   in_ready    loader idle; frame accepted when in_valid && in_ready
//   in_data     channel c = in_data[c*CHAIN_BITS +: CHAIN_BITS]
//   DS          serial data, bit c drives chain c
//   SHCP        shift clock to all chains
//   STCP        storage latch clock to all chains
//   MR_         active-low chain clear
//   OE_         active-low output enable
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse in the IDLE cycle after a frame is latched
//
// Configuration macro: SR_CHAIN_BLANK_EN. When defined, OE_ is held high
// during the clear states, LATCH and BLANK_CYCLES cycles of a BLANK state,
// hiding the display while a scanned layer changes. When undefined, OE_ is
// tied low and BLANK_CYCLES is only range-checked.

module sr_chain_loader
  import sr_chain_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CHAIN_BITS   = 56,
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                           master_clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*CHAIN_BITS-1:0] in_data,
  output logic [CHANNELS-1:0]            DS,
  output logic                           SHCP,
  output logic                           STCP,
  output logic                           MR_,
  output logic                           OE_,
  output logic                           busy,
  output logic                           frame_done
);

  if ((CHANNELS < 1) || (CHAIN_BITS < 1) || (BLANK_CYCLES < 1)) begin : g_bad_param
    $error("sr_chain_loader: CHANNELS, CHAIN_BITS and BLANK_CYCLES must be >= 1");
  end

  localparam int               BIT_W     = sr_cnt_width(CHAIN_BITS);
  localparam logic [BIT_W-1:0] BITS_LOAD = BIT_W'(CHAIN_BITS);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};

  sr_state_t                            state_r;
  logic [CHANNELS-1:0][CHAIN_BITS-1:0]  shadow_r;
  logic [CHANNELS-1:0][CHAIN_BITS-1:0]  shadow_shift_s;
  logic [CHANNELS-1:0]                  ds_r;
  logic [CHANNELS-1:0]                  ds_load_s;
  logic [CHANNELS-1:0]                  ds_next_s;
  logic [BIT_W-1:0]                     bit_cnt_r;
  logic                                 shcp_r;
  logic                                 stcp_r;
  logic                                 mr_n_r;
  logic                                 in_ready_r;
  logic                                 busy_r;
  logic                                 frame_done_r;
  logic                                 tick_s;
  logic                                 restart_s;

`ifdef SR_CHAIN_BLANK_EN
  localparam int                 BLANK_W    = sr_cnt_width(BLANK_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
  localparam logic [BLANK_W-1:0] BLANK_ZERO = {BLANK_W{1'b0}};

  logic [BLANK_W-1:0] blank_cnt_r;
  logic               oe_n_r;

  assign OE_ = oe_n_r;
`else
  assign OE_ = 1'b0;
`endif

  // The divider idles in reload while waiting for a frame, so the first
  // SHIFT_LO interval starts cleanly on the cycle after the handshake.
  assign restart_s = (state_r == ST_IDLE);

  sr_div_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk     (master_clk),
    .reset   (reset),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Per-channel MSB of the incoming frame and of the shadow after one shift.
  always_comb begin
    shadow_shift_s = '0;
    ds_load_s      = '0;
    ds_next_s      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      shadow_shift_s[c] = shadow_r[c] << 1'b1;
      ds_next_s[c]      = shadow_shift_s[c][CHAIN_BITS-1];
      ds_load_s[c]      = in_data[c*CHAIN_BITS + CHAIN_BITS - 1];
    end
  end

  // Loader FSM; every output is a register updated on state transitions.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_r      <= ST_CLEAR_MR;
      shadow_r     <= '0;
      bit_cnt_r    <= BIT_ZERO;
      ds_r         <= '0;
      shcp_r       <= 1'b0;
      stcp_r       <= 1'b0;
      mr_n_r       <= 1'b0;
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b1;
      frame_done_r <= 1'b0;
`ifdef SR_CHAIN_BLANK_EN
      oe_n_r       <= 1'b1;
      blank_cnt_r  <= BLANK_ZERO;
`endif
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_CLEAR_MR: begin
          if (tick_s) begin
            // Latch the cleared shift stage so the chain outputs read zero.
            state_r <= ST_CLEAR_LATCH;
            stcp_r  <= 1'b1;
          end else begin
            state_r <= ST_CLEAR_MR;
          end
        end

        ST_CLEAR_LATCH: begin
          if (tick_s) begin
            state_r    <= ST_IDLE;
            stcp_r     <= 1'b0;
            mr_n_r     <= 1'b1;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
`ifdef SR_CHAIN_BLANK_EN
            oe_n_r     <= 1'b0;
`endif
          end else begin
            state_r <= ST_CLEAR_LATCH;
          end
        end

        ST_IDLE: begin
          if (in_valid) begin
            state_r    <= ST_SHIFT_LO;
            shadow_r   <= in_data;
            bit_cnt_r  <= BITS_LOAD;
            ds_r       <= ds_load_s;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SHIFT_LO: begin
          if (tick_s) begin
            state_r <= ST_SHIFT_HI;
            shcp_r  <= 1'b1;
          end else begin
            state_r <= ST_SHIFT_LO;
          end
        end

        ST_SHIFT_HI: begin
          if (tick_s) begin
            // DS only moves on the falling SHCP edge, giving a full
            // CLK_DIV of hold after the rise and of setup before the next.
            shcp_r    <= 1'b0;
            shadow_r  <= shadow_shift_s;
            bit_cnt_r <= bit_cnt_r - BIT_ONE;
            if (bit_cnt_r == BIT_ONE) begin
              state_r <= ST_LATCH;
              stcp_r  <= 1'b1;
              ds_r    <= '0;
`ifdef SR_CHAIN_BLANK_EN
              oe_n_r  <= 1'b1;
`endif
            end else begin
              state_r <= ST_SHIFT_LO;
              ds_r    <= ds_next_s;
            end
          end else begin
            state_r <= ST_SHIFT_HI;
          end
        end

        ST_LATCH: begin
          if (tick_s) begin
            stcp_r <= 1'b0;
`ifdef SR_CHAIN_BLANK_EN
            state_r     <= ST_BLANK;
            blank_cnt_r <= BLANK_LOAD;
`else
            state_r      <= ST_IDLE;
            frame_done_r <= 1'b1;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
`endif
          end else begin
            state_r <= ST_LATCH;
          end
        end

`ifdef SR_CHAIN_BLANK_EN
        ST_BLANK: begin
          if (blank_cnt_r == BLANK_ZERO) begin
            state_r      <= ST_IDLE;
            oe_n_r       <= 1'b0;
            frame_done_r <= 1'b1;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            state_r     <= ST_BLANK;
            blank_cnt_r <= blank_cnt_r - BLANK_ONE;
          end
        end
`endif

        default: begin
          // Unreachable encoding: recover through a full clear sequence.
          state_r    <= ST_CLEAR_MR;
          ds_r       <= '0;
          shcp_r     <= 1'b0;
          stcp_r     <= 1'b0;
          mr_n_r     <= 1'b0;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b1;
`ifdef SR_CHAIN_BLANK_EN
          oe_n_r     <= 1'b1;
`endif
        end
      endcase
    end
  end

  assign DS         = ds_r;
  assign SHCP       = shcp_r;
  assign STCP       = stcp_r;
  assign MR_        = mr_n_r;
  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sr_chain_loader.sv
// Self-checking bench for sr_chain_loader: 2 channels of 16-bit chains
// (two 595s each), CLK_DIV=2. Two behavioural 595 chains are fed by the DUT
// strobes and their storage outputs are compared against the frame words.

module tb_sr_chain_loader;
  import sr_chain_pkg::*;

  localparam int CH = 2;
  localparam int CB = 16;
  localparam int CD = 2;
  localparam int BC = 8;
`ifdef SR_CHAIN_BLANK_EN
  localparam int BLANK_ON = 1;
`else
  localparam int BLANK_ON = 0;
`endif
  localparam int SB     = 2 * CD * CB;                     // last SHIFT cycle
  localparam int F_EXP  = (2 * CB + 1) * CD + 1 + BLANK_ON * BC;
  localparam int BUDGET = sr_frame_cycles(CB, CD, BC) + 20;

  logic             master_clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [CH*CB-1:0] in_data;
  logic [CH-1:0]    DS;
  logic             SHCP, STCP, MR_, OE_, busy, frame_done;

  sr_chain_loader #(
    .CHANNELS(CH), .CHAIN_BITS(CB), .CLK_DIV(CD), .BLANK_CYCLES(BC)
  ) dut (
    .master_clk(master_clk), .reset(reset), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .DS(DS), .SHCP(SHCP),
    .STCP(STCP), .MR_(MR_), .OE_(OE_), .busy(busy), .frame_done(frame_done)
  );

  always #5 master_clk = ~master_clk;

  int cyc = 0;
  always @(posedge master_clk) cyc <= cyc + 1;

  // Behavioural 595 chains plus DS setup/hold monitor, sampled mid-cycle.
  logic [CB-1:0] sr0, sr1, q0, q1;
  logic          shcp_q = 1'b0;
  logic          stcp_q = 1'b0;
  logic [CH-1:0] ds_q;
  int            last_rise = -100;
  int            last_ds   = -100;
  int            n_shcp    = 0;
  int            n_stcp    = 0;
  int            viol      = 0;
  bit            stab_en   = 1'b0;

  always @(negedge master_clk) begin
    if (MR_ !== 1'b1) begin
      sr0 <= '0;
      sr1 <= '0;
    end else if (SHCP === 1'b1 && shcp_q === 1'b0) begin
      sr0 <= {sr0[CB-2:0], DS[0]};
      sr1 <= {sr1[CB-2:0], DS[1]};
    end
    if (STCP === 1'b1 && stcp_q === 1'b0) begin
      q0     <= sr0;
      q1     <= sr1;
      n_stcp <= n_stcp + 1;
    end
    if (SHCP === 1'b1 && shcp_q === 1'b0) begin
      n_shcp    <= n_shcp + 1;
      last_rise <= cyc;
      if (stab_en && (cyc - last_ds) < CD) viol <= viol + 1;
    end
    if (DS !== ds_q) begin
      last_ds <= cyc;
      if (stab_en && (cyc - last_rise) < CD) viol <= viol + 1;
    end
    shcp_q <= SHCP;
    stcp_q <= STCP;
    ds_q   <= DS;
  end

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_ds", 64'(DS), 64'(0));
    chk("rst_shcp", 64'(SHCP), 64'(0));
    chk("rst_stcp", 64'(STCP), 64'(0));
    chk("rst_mr", 64'(MR_), 64'(0));
    chk("rst_oe", 64'(OE_), 64'(BLANK_ON));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
  endtask

  // Called at the mid-cycle point of the handshake cycle (in_valid already
  // high with {w1,w0}). Follows the frame to frame_done, checking every
  // strobe against the cycle-level timing. With chain_next the next frame
  // {nw1,nw0} is offered with in_valid kept high throughout.
  task automatic run_frame(input logic [CB-1:0] w0, input logic [CB-1:0] w1,
                           input bit chain_next,
                           input logic [CB-1:0] nw0, input logic [CB-1:0] nw1);
    int         c0, n, done_n, sh0, st0, v0, i;
    logic [1:0] ds_exp;
    c0 = cyc; sh0 = n_shcp; st0 = n_stcp; v0 = viol; done_n = -1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge master_clk);
      n = cyc - c0;
      if (n == 1) begin
        if (chain_next) begin
          in_data = {nw1, nw0};
        end else begin
          in_valid = 1'b0;
          in_data  = $urandom();
        end
      end
      if (frame_done === 1'b1) begin
        done_n = n;
        break;
      end
      if (n >= 1 && n <= SB) begin
        i      = (n - 1) / (2 * CD);
        ds_exp = {w1[CB-1-i], w0[CB-1-i]};
      end else begin
        ds_exp = 2'b00;
      end
      chk($sformatf("shcp@%0d", n), 64'(SHCP),
          64'((n >= 1 && n <= SB) ? (((n - 1) / CD) % 2) : 0));
      chk($sformatf("stcp@%0d", n), 64'(STCP), 64'(n > SB && n <= SB + CD));
      chk($sformatf("oe@%0d", n), 64'(OE_), 64'(BLANK_ON == 1 && n > SB));
      chk($sformatf("ds@%0d", n), 64'(DS), 64'(ds_exp));
      chk($sformatf("in_ready@%0d", n), 64'(in_ready), 64'(0));
      chk($sformatf("busy@%0d", n), 64'(busy), 64'(1));
    end
    chk("frame_done_cycle", 64'(done_n), 64'(F_EXP));
    chk("chain_q0", 64'(q0), 64'(w0));
    chk("chain_q1", 64'(q1), 64'(w1));
    chk("shcp_rises", 64'(n_shcp - sh0), 64'(CB));
    chk("stcp_rises", 64'(n_stcp - st0), 64'(1));
    chk("ds_setup_hold_violations", 64'(viol - v0), 64'(0));
    chk("done_in_ready", 64'(in_ready), 64'(1));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_oe", 64'(OE_), 64'(0));
    chk("done_ds", 64'(DS), 64'(0));
  endtask

  initial begin
    logic [CB-1:0] cur0, cur1, nxt0, nxt1;
    bit            chain;
    int            n, c0, rk, fd;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge master_clk);
    @(negedge master_clk);
    chk_reset_values();
    reset = 1'b0;

    // Clear sequence: MR_ low 2 cycles, STCP pulse with MR_ low, then IDLE.
    for (int k = 1; k <= 4; k++) begin
      @(negedge master_clk);
      chk($sformatf("clr_mr@%0d", k), 64'(MR_), 64'(k == 4));
      chk($sformatf("clr_stcp@%0d", k), 64'(STCP), 64'(k == 2 || k == 3));
      chk($sformatf("clr_in_ready@%0d", k), 64'(in_ready), 64'(k == 4));
    end
    chk("clr_q0", 64'(q0), 64'(0));
    chk("clr_q1", 64'(q1), 64'(0));
    stab_en = 1'b1;

    // Single directed frame.
    in_valid = 1'b1;
    in_data  = {16'h0001, 16'hA5C3};
    run_frame(16'hA5C3, 16'h0001, 1'b0, 16'h0000, 16'h0000);

    // in_valid held across two frames: second accepted in frame_done cycle.
    cur1     = 16'($urandom());
    nxt1     = 16'($urandom());
    in_valid = 1'b1;
    in_data  = {cur1, 16'hFFFF};
    run_frame(16'hFFFF, cur1, 1'b1, 16'h1234, nxt1);
    run_frame(16'h1234, nxt1, 1'b0, 16'h0000, 16'h0000);

    // Random frames, randomly chained or separated by idle cycles.
    cur0     = 16'($urandom());
    cur1     = 16'($urandom());
    in_valid = 1'b1;
    in_data  = {cur1, cur0};
    for (int t = 0; t < 5; t++) begin
      nxt0  = 16'($urandom());
      nxt1  = 16'($urandom());
      chain = (t < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(cur0, cur1, chain, nxt0, nxt1);
      if (!chain && t < 4) begin
        repeat ($urandom_range(1, 3)) @(negedge master_clk);
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_data  = {nxt1, nxt0};
      end
      cur0 = nxt0;
      cur1 = nxt1;
    end

    // Abort: reset asserted at cycle 20 of a frame.
    in_valid = 1'b1;
    in_data  = {16'($urandom()) | 16'h0001, 16'($urandom()) | 16'h8000};
    c0       = cyc;
    n        = 0;
    for (int k = 0; k < BUDGET && n < 20; k++) begin
      @(negedge master_clk);
      n = cyc - c0;
      if (n == 1) in_valid = 1'b0;
    end
    stab_en = 1'b0;
    reset   = 1'b1;
    @(negedge master_clk);
    chk_reset_values();
    reset = 1'b0;
    rk    = -1;
    fd    = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge master_clk);
      if (frame_done === 1'b1) fd++;
      if (in_ready === 1'b1) begin
        rk = k;
        break;
      end
    end
    chk("abort_ready_cycle", 64'(rk), 64'(2 * CD));
    chk("abort_no_frame_done", 64'(fd), 64'(0));
    chk("abort_q0", 64'(q0), 64'(0));
    chk("abort_q1", 64'(q1), 64'(0));
    stab_en = 1'b1;

    // Recovery frame after the abort.
    cur0     = 16'($urandom());
    cur1     = 16'($urandom());
    in_valid = 1'b1;
    in_data  = {cur1, cur0};
    run_frame(cur0, cur1, 1'b0, 16'h0000, 16'h0000);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
